// File: rtl/pipe_ctrl_unit.sv
// Control unit for a 5-stage pipeline: decodes the ID instruction, carries its control
// word through ID/EX, EX/MEM and MEM/WB, and produces stall/flush/freeze/forwarding controls.
module pipe_ctrl_unit #(
   parameter int unsigned FWD_EN = 1,
   parameter int unsigned ALUC_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       id_instr,
   input  logic              ex_zero,
   input  logic              MIO_ready,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic [1:0]        pc_src,
   output logic              ex_RegDst,
   output logic              ex_ALUSrc_B,
   output logic [ALUC_W-1:0] ex_ALU_Control,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              mem_read,
   output logic              mem_w,
   output logic              wb_RegWrite,
   output logic              wb_MemtoReg,
   output logic [4:0]        wb_wreg,
   output logic              illegal
);

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src_b;
      logic [3:0] alu;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       is_bne;
      logic       reg_write;
      logic       mem_to_reg;
      logic [4:0] dest;
      logic [4:0] rs;
      logic [4:0] rt;
   } ex_cw_t;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic [4:0] dest;
   } mem_cw_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic [4:0] dest;
   } wb_cw_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam bit         FWD_ON  = (FWD_EN != 0);

   // A zero destination never matches, so r0 writers never create a hazard.
   function automatic logic src_hit(input logic [4:0] dest, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic uses_rt);
      return (dest != 5'd0) && ((dest == rs) || (uses_rt && (dest == rt)));
   endfunction

   ex_cw_t  id_cw_s, ex_d, ex_q;
   mem_cw_t mem_d, mem_q;
   wb_cw_t  wb_d, wb_q;
   logic    illegal_d, illegal_q;
   logic    id_legal_s, id_uses_rt_s, id_jump_s;
   logic    mem_w_s, freeze_s, taken_s, stall_s;
   logic [ALUC_W-1:0] ex_alu_s;

   // Instruction decode of the IF/ID word into an ID/EX control word.
   always_comb begin
      id_cw_s      = '0;
      id_cw_s.alu  = ALU_ADD;
      id_legal_s   = 1'b1;
      id_uses_rt_s = 1'b0;
      id_jump_s    = 1'b0;
      case (id_instr[31:26])
         6'b000000: begin
            id_cw_s.reg_dst   = 1'b1;
            id_cw_s.reg_write = 1'b1;
            id_uses_rt_s      = 1'b1;
            case (id_instr[5:0])
               6'b100000: id_cw_s.alu = ALU_ADD;
               6'b100010: id_cw_s.alu = ALU_SUB;
               6'b100100: id_cw_s.alu = ALU_AND;
               6'b100101: id_cw_s.alu = ALU_OR;
               6'b100110: id_cw_s.alu = ALU_XOR;
               6'b101010: id_cw_s.alu = ALU_SLT;
               6'b100111: id_cw_s.alu = ALU_NOR;
               6'b000010: id_cw_s.alu = ALU_SRL;
               default:   id_legal_s  = 1'b0;
            endcase
         end
         6'b100011: begin
            id_cw_s.alu_src_b  = 1'b1;
            id_cw_s.mem_read   = 1'b1;
            id_cw_s.mem_to_reg = 1'b1;
            id_cw_s.reg_write  = 1'b1;
         end
         6'b101011: begin
            id_cw_s.alu_src_b = 1'b1;
            id_cw_s.mem_write = 1'b1;
            id_uses_rt_s      = 1'b1;
         end
         6'b000100, 6'b000101: begin
            id_cw_s.branch = 1'b1;
            id_cw_s.is_bne = id_instr[26];
            id_cw_s.alu    = ALU_SUB;
            id_uses_rt_s   = 1'b1;
         end
         6'b000010: id_jump_s = 1'b1;
         6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
            id_cw_s.alu_src_b = 1'b1;
            id_cw_s.reg_write = 1'b1;
            case (id_instr[28:26])
               3'b010:  id_cw_s.alu = ALU_SLT;
               3'b100:  id_cw_s.alu = ALU_AND;
               3'b101:  id_cw_s.alu = ALU_OR;
               default: id_cw_s.alu = ALU_ADD;
            endcase
         end
         default: id_legal_s = 1'b0;
      endcase
      // The all-zero word is the pipeline NOP that flushes load into IF/ID.
      if (id_instr == 32'd0) begin
         id_cw_s      = '0;
         id_legal_s   = 1'b1;
         id_uses_rt_s = 1'b0;
      end else if (!id_legal_s) begin
         id_cw_s      = '0;
         id_cw_s.alu  = ALU_ADD;
         id_uses_rt_s = 1'b0;
         id_jump_s    = 1'b0;
      end else begin
         id_cw_s.rs   = id_instr[25:21];
         id_cw_s.rt   = id_instr[20:16];
         id_cw_s.dest = id_cw_s.reg_write ?
                        (id_cw_s.reg_dst ? id_instr[15:11] : id_instr[20:16]) : 5'd0;
      end
   end

   assign mem_w_s  = mem_q.mem_write & ~mem_q.mem_read;
   assign freeze_s = ~MIO_ready & (mem_q.mem_read | mem_w_s);
   assign taken_s  = ex_q.branch & (ex_zero ^ ex_q.is_bne);
   assign stall_s  = FWD_ON ?
      (ex_q.mem_read & src_hit(ex_q.dest, id_cw_s.rs, id_cw_s.rt, id_uses_rt_s)) :
      ((ex_q.reg_write & src_hit(ex_q.dest, id_cw_s.rs, id_cw_s.rt, id_uses_rt_s)) |
       (mem_q.reg_write & src_hit(mem_q.dest, id_cw_s.rs, id_cw_s.rt, id_uses_rt_s)));

   // Hazard resolution and next values of the stage control registers.
   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      pc_src     = 2'b00;
      ex_d       = id_cw_s;
      mem_d      = '{ex_q.mem_read, ex_q.mem_write, ex_q.reg_write, ex_q.mem_to_reg, ex_q.dest};
      wb_d       = '{mem_q.reg_write, mem_q.mem_to_reg, mem_q.dest};
      illegal_d  = ~id_legal_s;
      if (freeze_s) begin
         // A pending taken branch simply waits in EX and resolves once memory is ready.
         pc_en     = 1'b0;
         ifid_en   = 1'b0;
         ex_d      = ex_q;
         mem_d     = mem_q;
         wb_d      = wb_q;
         illegal_d = 1'b0;
      end else if (taken_s) begin
         pc_src     = 2'b01;
         ifid_flush = 1'b1;
         ex_d       = '0;
         illegal_d  = 1'b0;
      end else if (stall_s) begin
         pc_en     = 1'b0;
         ifid_en   = 1'b0;
         ex_d      = '0;
         illegal_d = 1'b0;
      end else if (id_jump_s) begin
         pc_src     = 2'b10;
         ifid_flush = 1'b1;
      end else begin
         pc_src = 2'b00;
      end
   end

   // EX operand forwarding; the younger MEM result wins over WB.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (FWD_ON && mem_q.reg_write && (mem_q.dest != 5'd0) && (mem_q.dest == ex_q.rs)) begin
         fwd_a = 2'b10;
      end else if (FWD_ON && wb_q.reg_write && (wb_q.dest != 5'd0) && (wb_q.dest == ex_q.rs)) begin
         fwd_a = 2'b01;
      end else begin
         fwd_a = 2'b00;
      end
      if (FWD_ON && mem_q.reg_write && (mem_q.dest != 5'd0) && (mem_q.dest == ex_q.rt)) begin
         fwd_b = 2'b10;
      end else if (FWD_ON && wb_q.reg_write && (wb_q.dest != 5'd0) && (wb_q.dest == ex_q.rt)) begin
         fwd_b = 2'b01;
      end else begin
         fwd_b = 2'b00;
      end
   end

   // Stage control registers; reset loads bubbles everywhere.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         ex_q      <= ex_d;
         mem_q     <= mem_d;
         wb_q      <= wb_d;
         illegal_q <= illegal_d;
      end
   end

   // Zero-extend the 4-bit ALU code to the configured width.
   always_comb begin
      ex_alu_s      = '0;
      ex_alu_s[3:0] = ex_q.alu;
   end

   assign ex_RegDst      = ex_q.reg_dst;
   assign ex_ALUSrc_B    = ex_q.alu_src_b;
   assign ex_ALU_Control = ex_alu_s;
   assign mem_read       = mem_q.mem_read;
   assign mem_w          = mem_w_s;
   assign wb_RegWrite    = wb_q.reg_write;
   assign wb_MemtoReg    = wb_q.mem_to_reg;
   assign wb_wreg        = wb_q.dest;
   assign illegal        = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one forwarding instance and one stall-only instance,
// driven with hand-built instruction streams and hand-computed expectations.
module tb_pipe_ctrl_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, ex_zero, mio_ready;
   logic [31:0] id_instr, id_instr_nf;

   logic       pc_en, ifid_en, ifid_flush, ex_reg_dst, ex_alu_src_b;
   logic [1:0] pc_src, fwd_a, fwd_b;
   logic [3:0] ex_alu;
   logic       mem_read, mem_w, wb_reg_write, wb_mem_to_reg, illegal;
   logic [4:0] wb_wreg;

   logic       nf_pc_en, nf_ifid_en, nf_ifid_flush, nf_ex_reg_dst, nf_ex_alu_src_b;
   logic [1:0] nf_pc_src, nf_fwd_a, nf_fwd_b;
   logic [3:0] nf_ex_alu;
   logic       nf_mem_read, nf_mem_w, nf_wb_reg_write, nf_wb_mem_to_reg, nf_illegal;
   logic [4:0] nf_wb_wreg;

   int n_checks = 0;
   int n_errors = 0;

   pipe_ctrl_unit #(.FWD_EN(1), .ALUC_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .ex_zero(ex_zero), .MIO_ready(mio_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .pc_src(pc_src),
      .ex_RegDst(ex_reg_dst), .ex_ALUSrc_B(ex_alu_src_b), .ex_ALU_Control(ex_alu),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_read(mem_read), .mem_w(mem_w),
      .wb_RegWrite(wb_reg_write), .wb_MemtoReg(wb_mem_to_reg), .wb_wreg(wb_wreg),
      .illegal(illegal));

   pipe_ctrl_unit #(.FWD_EN(0), .ALUC_W(4)) dut_nf (
      .clk(clk), .rst_n(rst_n), .id_instr(id_instr_nf), .ex_zero(ex_zero), .MIO_ready(mio_ready),
      .pc_en(nf_pc_en), .ifid_en(nf_ifid_en), .ifid_flush(nf_ifid_flush), .pc_src(nf_pc_src),
      .ex_RegDst(nf_ex_reg_dst), .ex_ALUSrc_B(nf_ex_alu_src_b), .ex_ALU_Control(nf_ex_alu),
      .fwd_a(nf_fwd_a), .fwd_b(nf_fwd_b), .mem_read(nf_mem_read), .mem_w(nf_mem_w),
      .wb_RegWrite(nf_wb_reg_write), .wb_MemtoReg(nf_wb_mem_to_reg), .wb_wreg(nf_wb_wreg),
      .illegal(nf_illegal));

   // {pc_en, ifid_en, ifid_flush, pc_src}
   wire [4:0] hz    = {pc_en, ifid_en, ifid_flush, pc_src};
   wire [4:0] nf_hz = {nf_pc_en, nf_ifid_en, nf_ifid_flush, nf_pc_src};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
      return {6'b000000, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Advance to just after the next rising edge; inputs are driven there.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   localparam logic [31:0] NOP = 32'd0;

   initial begin
      rst_n = 1'b1; id_instr = NOP; id_instr_nf = NOP; ex_zero = 1'b0; mio_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check_eq("rst_hz", {27'd0, hz}, 32'h18);
      check_eq("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'h0);
      check_eq("rst_ex", {26'd0, ex_reg_dst, ex_alu_src_b, ex_alu}, 32'h0);
      check_eq("rst_mem", {30'd0, mem_read, mem_w}, 32'h0);
      check_eq("rst_wb", {25'd0, wb_reg_write, wb_mem_to_reg, wb_wreg}, 32'h0);
      check_eq("rst_illegal", {31'd0, illegal}, 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // Load-use: lw $2,0($1) ; add $3,$2,$4
      id_instr = enc_i(6'b100011, 5'd1, 5'd2, 16'd0); #1;
      check_eq("lu_c0_hz", {27'd0, hz}, 32'h18);
      step(); id_instr = enc_r(5'd2, 5'd4, 5'd3, 6'b100000); #1;
      check_eq("lu_stall_hz", {27'd0, hz}, 32'h00);
      check_eq("lu_lw_ex", {26'd0, ex_reg_dst, ex_alu_src_b, ex_alu}, 32'h12);
      step(); #1;
      check_eq("lu_resume_hz", {27'd0, hz}, 32'h18);
      check_eq("lu_bubble_ex", {26'd0, ex_reg_dst, ex_alu_src_b, ex_alu}, 32'h0);
      check_eq("lu_lw_mem", {30'd0, mem_read, mem_w}, 32'h2);
      step(); id_instr = NOP; #1;
      check_eq("lu_add_ex", {26'd0, ex_reg_dst, ex_alu_src_b, ex_alu}, 32'h22);
      check_eq("lu_fwd", {28'd0, fwd_a, fwd_b}, 32'h4);
      check_eq("lu_lw_wb", {25'd0, wb_reg_write, wb_mem_to_reg, wb_wreg}, 32'h62);
      step(); step(); step();

      // Forwarding: add $1 ; add $1 ; sub $5,$1,$1 ; or $8,$7,$1
      id_instr = enc_r(5'd6, 5'd7, 5'd1, 6'b100000); #1;
      step(); id_instr = enc_r(5'd2, 5'd3, 5'd1, 6'b100000); #1;
      check_eq("fw_no_stall1", {31'd0, pc_en}, 32'h1);
      step(); id_instr = enc_r(5'd1, 5'd1, 5'd5, 6'b100010); #1;
      check_eq("fw_no_stall2", {31'd0, pc_en}, 32'h1);
      step(); id_instr = enc_r(5'd7, 5'd1, 5'd8, 6'b100101); #1;
      check_eq("fw_sub_alu", {28'd0, ex_alu}, 32'h6);
      check_eq("fw_mem_wins", {28'd0, fwd_a, fwd_b}, 32'hA);
      step(); id_instr = NOP; #1;
      check_eq("fw_or_alu", {28'd0, ex_alu}, 32'h1);
      check_eq("fw_wb_b", {28'd0, fwd_a, fwd_b}, 32'h1);
      step(); step(); step();

      // r0 destinations never forward or stall
      id_instr = enc_r(5'd2, 5'd3, 5'd0, 6'b100000); #1;
      step(); id_instr = enc_r(5'd0, 5'd0, 5'd9, 6'b100000); #1;
      step(); id_instr = enc_i(6'b100011, 5'd1, 5'd0, 16'd4); #1;
      check_eq("r0_fwd", {28'd0, fwd_a, fwd_b}, 32'h0);
      step(); id_instr = enc_r(5'd0, 5'd4, 5'd3, 6'b100000); #1;
      check_eq("r0_lu_no_stall", {27'd0, hz}, 32'h18);
      step(); id_instr = NOP; step(); step(); step();

      // No forwarding: add $1 ; sub $5,$1,$1 stalls two cycles
      id_instr_nf = enc_r(5'd2, 5'd3, 5'd1, 6'b100000); #1;
      step(); id_instr_nf = enc_r(5'd1, 5'd1, 5'd5, 6'b100010); #1;
      check_eq("nf_stall1", {27'd0, nf_hz}, 32'h00);
      step(); #1;
      check_eq("nf_stall2", {27'd0, nf_hz}, 32'h00);
      step(); #1;
      check_eq("nf_release", {27'd0, nf_hz}, 32'h18);
      step(); id_instr_nf = NOP; #1;
      check_eq("nf_sub_alu", {28'd0, nf_ex_alu}, 32'h6);
      check_eq("nf_fwd", {28'd0, nf_fwd_a, nf_fwd_b}, 32'h0);
      step(); step(); step();

      // Taken bne (ex_zero=0), then flushed wrong path
      id_instr = enc_i(6'b000101, 5'd1, 5'd2, 16'd8); #1;
      check_eq("bne_id_hz", {27'd0, hz}, 32'h18);
      step(); id_instr = enc_r(5'd2, 5'd3, 5'd10, 6'b100000); ex_zero = 1'b0; #1;
      check_eq("bne_taken_hz", {27'd0, hz}, 32'h19 | 32'h04);
      step(); id_instr = NOP; #1;
      check_eq("bne_bubble_ex", {26'd0, ex_reg_dst, ex_alu_src_b, ex_alu}, 32'h0);
      check_eq("bne_after_hz", {27'd0, hz}, 32'h18);
      step(); #1;
      check_eq("bne_mem", {30'd0, mem_read, mem_w}, 32'h0);
      step(); #1;
      check_eq("bne_wrong_wb", {25'd0, wb_reg_write, wb_mem_to_reg, wb_wreg}, 32'h0);
      step(); step();

      // Not-taken beq (ex_zero=0)
      id_instr = enc_i(6'b000100, 5'd1, 5'd2, 16'd8); #1;
      step(); id_instr = enc_r(5'd2, 5'd3, 5'd10, 6'b100000); ex_zero = 1'b0; #1;
      check_eq("beq_nt_hz", {27'd0, hz}, 32'h18);
      step(); id_instr = NOP; #1;
      check_eq("beq_nt_add_ex", {31'd0, ex_reg_dst}, 32'h1);
      step(); step(); step();

      // Freeze: sw in MEM, MIO_ready low 3 cycles, taken beq in EX
      id_instr = enc_i(6'b101011, 5'd1, 5'd2, 16'd0); #1;
      step(); id_instr = enc_i(6'b000100, 5'd3, 5'd4, 16'd8); #1;
      check_eq("frz_sw_ex", {26'd0, ex_reg_dst, ex_alu_src_b, ex_alu}, 32'h12);
      step(); id_instr = enc_r(5'd5, 5'd6, 5'd7, 6'b100000);
      for (int k = 0; k < 3; k++) begin
         mio_ready = 1'b0; ex_zero = 1'b1; #1;
         check_eq($sformatf("frz_hz%0d", k), {29'd0, pc_en, ifid_en, ifid_flush}, 32'h0);
         check_eq($sformatf("frz_ex%0d", k), {28'd0, ex_alu}, 32'h6);
         check_eq($sformatf("frz_mem%0d", k), {30'd0, mem_read, mem_w}, 32'h1);
         step();
      end
      mio_ready = 1'b1; ex_zero = 1'b1; #1;
      check_eq("frz_flush", {27'd0, hz}, 32'h1D);
      step(); id_instr = NOP; ex_zero = 1'b0; #1;
      check_eq("frz_once", {27'd0, hz}, 32'h18);
      check_eq("frz_bubble_ex", {26'd0, ex_reg_dst, ex_alu_src_b, ex_alu}, 32'h0);
      check_eq("frz_beq_mem", {30'd0, mem_read, mem_w}, 32'h0);
      step(); step(); step();

      // Illegal opcode and illegal funct
      id_instr = {6'b111111, 26'd0}; #1;
      check_eq("ill_id_hz", {27'd0, hz}, 32'h18);
      step(); id_instr = NOP; #1;
      check_eq("ill_flag", {31'd0, illegal}, 32'h1);
      check_eq("ill_ex", {26'd0, ex_reg_dst, ex_alu_src_b, ex_alu}, 32'h2);
      step(); #1;
      check_eq("ill_flag_clr", {31'd0, illegal}, 32'h0);
      check_eq("ill_mem", {30'd0, mem_read, mem_w}, 32'h0);
      step(); #1;
      check_eq("ill_wb", {25'd0, wb_reg_write, wb_mem_to_reg, wb_wreg}, 32'h0);
      id_instr = enc_r(5'd1, 5'd2, 5'd3, 6'b111111);
      step(); id_instr = NOP; #1;
      check_eq("ill_funct", {31'd0, illegal}, 32'h1);
      step(); step(); step();

      // Jump in ID
      id_instr = {6'b000010, 26'h0000040}; #1;
      check_eq("j_hz", {27'd0, hz}, 32'h1E);
      step(); id_instr = NOP; #1;
      check_eq("j_after_hz", {27'd0, hz}, 32'h18);
      check_eq("j_word_ex", {26'd0, ex_reg_dst, ex_alu_src_b, ex_alu}, 32'h2);
      check_eq("j_illegal", {31'd0, illegal}, 32'h0);
      step(); step();

      // Reset while an lw is in MEM
      id_instr = enc_i(6'b100011, 5'd1, 5'd2, 16'd0); #1;
      step(); id_instr = enc_r(5'd5, 5'd6, 5'd7, 6'b100000); #1;
      step(); id_instr = NOP; #1;
      check_eq("rm_pre_mem", {30'd0, mem_read, mem_w}, 32'h2);
      rst_n = 1'b0; #1;
      check_eq("rm_ex", {26'd0, ex_reg_dst, ex_alu_src_b, ex_alu}, 32'h0);
      check_eq("rm_mem", {30'd0, mem_read, mem_w}, 32'h0);
      check_eq("rm_hz", {27'd0, hz}, 32'h18);
      step(); rst_n = 1'b1; #1;
      step(); #1;
      check_eq("rm_wb", {25'd0, wb_reg_write, wb_mem_to_reg, wb_wreg}, 32'h0);
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
